// File: rtl/lfsr_keystream_pkg.sv
// Shared types and constants for the LFSR keystream generator.
package lfsr_keystream_pkg;

   typedef enum logic {
      LFSR_FIBONACCI = 1'b0,
      LFSR_GALOIS    = 1'b1
   } lfsr_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } lfsr_fsm_e;

   // State forced in whenever the register would otherwise sit at all-zeros.
   localparam int unsigned LFSR_RESEED = 1;

endpackage

// File: rtl/lfsr_keystream_step_n.sv
// Combinational OUT_WIDTH-step LFSR advance; the first step's output bit lands in the word MSB.
module lfsr_keystream_step_n
   import lfsr_keystream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OUT_WIDTH  = 8
) (
   input  logic [DATA_WIDTH-1:0] i_state,
   input  logic [DATA_WIDTH:0]   i_taps,
   input  lfsr_mode_e            i_mode,
   output logic [OUT_WIDTH-1:0]  o_word,
   output logic [DATA_WIDTH-1:0] o_next
);

   for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_step
      logic [DATA_WIDTH-1:0] w_in;
      logic [DATA_WIDTH-1:0] w_fib;
      logic [DATA_WIDTH-1:0] w_gal;
      logic [DATA_WIDTH-1:0] w_out;
      logic                  w_msb;
      logic                  w_fib_fb;

      if (g == 0) begin : g_first
         assign w_in = i_state;
      end else begin : g_rest
         assign w_in = g_step[g-1].w_out;
      end

      assign w_msb    = w_in[DATA_WIDTH-1];
      assign w_fib_fb = ^(w_in & i_taps[DATA_WIDTH:1]);
      assign w_fib    = {w_in[DATA_WIDTH-2:0], w_fib_fb};
      assign w_gal    = {w_in[DATA_WIDTH-2:0], 1'b0} ^
                        ({DATA_WIDTH{w_msb}} & i_taps[DATA_WIDTH-1:0]);
      assign w_out    = (i_mode == LFSR_GALOIS) ? w_gal : w_fib;

      assign o_word[OUT_WIDTH-1-g] = w_msb;
   end

   assign o_next = g_step[OUT_WIDTH-1].w_out;

endmodule

// File: rtl/lfsr_keystream.sv
// LFSR keystream generator: seed load, length-bounded bursts over valid/ready, zero-lockup reseed.
module lfsr_keystream
   import lfsr_keystream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_seed,
   input  logic [DATA_WIDTH:0]   i_taps,
   input  logic                  i_mode,
   input  logic                  i_start,
   input  logic [LEN_WIDTH-1:0]  i_length,
   output logic [OUT_WIDTH-1:0]  o_out_data,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic                  o_done,
   output logic                  o_busy,
   output logic                  o_lockup,
   output logic [DATA_WIDTH-1:0] o_state
);

   localparam logic [DATA_WIDTH-1:0] RESEED = DATA_WIDTH'(LFSR_RESEED);

   lfsr_fsm_e             r_fsm;
   logic [DATA_WIDTH-1:0] r_state;
   logic [OUT_WIDTH-1:0]  r_out_data;
   logic                  r_out_valid;
   logic                  r_done;
   logic                  r_lockup;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [DATA_WIDTH:0]   r_taps;
   lfsr_mode_e            r_mode;

   logic [DATA_WIDTH:0]   w_taps;
   lfsr_mode_e            w_mode;
   logic [OUT_WIDTH-1:0]  w_word;
   logic [DATA_WIDTH-1:0] w_next;
   logic                  w_next_zero;
   logic                  w_accept;

   // The first word of a burst is generated with the taps/mode being captured that same cycle.
   assign w_taps      = (r_fsm == ST_IDLE) ? i_taps : r_taps;
   assign w_mode      = (r_fsm == ST_IDLE) ? lfsr_mode_e'(i_mode) : r_mode;
   assign w_next_zero = (w_next == '0);
   assign w_accept    = r_out_valid & i_out_ready;

   lfsr_keystream_step_n #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_step (
      .i_state (r_state),
      .i_taps  (w_taps),
      .i_mode  (w_mode),
      .o_word  (w_word),
      .o_next  (w_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm       <= ST_IDLE;
         r_state     <= RESEED;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_lockup    <= 1'b0;
         r_remaining <= '0;
         r_taps      <= '0;
         r_mode      <= LFSR_FIBONACCI;
      end else begin
         r_done <= 1'b0;
         unique case (r_fsm)
            ST_IDLE: begin
               if (i_load) begin
                  if (i_seed == '0) begin
                     r_state  <= RESEED;
                     r_lockup <= 1'b1;
                  end else begin
                     r_state  <= i_seed;
                     r_lockup <= 1'b0;
                  end
               end else if (i_start) begin
                  if (i_length == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_taps      <= i_taps;
                     r_mode      <= lfsr_mode_e'(i_mode);
                     r_out_data  <= w_word;
                     r_out_valid <= 1'b1;
                     r_remaining <= i_length;
                     r_fsm       <= ST_RUN;
                     if (w_next_zero) begin
                        r_state  <= RESEED;
                        r_lockup <= 1'b1;
                     end else begin
                        r_state <= w_next;
                     end
                  end
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  if (r_remaining > LEN_WIDTH'(1)) begin
                     r_out_data  <= w_word;
                     r_remaining <= r_remaining - LEN_WIDTH'(1);
                     if (w_next_zero) begin
                        r_state  <= RESEED;
                        r_lockup <= 1'b1;
                     end else begin
                        r_state <= w_next;
                     end
                  end else begin
                     r_out_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_remaining <= '0;
                     r_fsm       <= ST_IDLE;
                  end
               end
            end
            default: r_fsm <= ST_IDLE;
         endcase
      end
   end

   assign o_out_data  = r_out_data;
   assign o_out_valid = r_out_valid;
   assign o_done      = r_done;
   assign o_busy      = (r_fsm == ST_RUN);
   assign o_lockup    = r_lockup;
   assign o_state     = r_state;

endmodule

// File: tb/tb_lfsr_keystream.sv
// Directed self-checking bench: two 4-bit instances share stimulus, a 16-bit Galois instance runs the period test.
module tb_lfsr_keystream;

   logic clk = 1'b0;
   logic rst;

   logic        ab_load;
   logic [3:0]  ab_seed;
   logic [4:0]  ab_taps;
   logic        ab_mode;
   logic        ab_start;
   logic [15:0] ab_length;
   logic        ab_ready;

   logic [0:0]  a_data;
   logic        a_valid, a_done, a_busy, a_lockup;
   logic [3:0]  a_state;
   logic [3:0]  b_data;
   logic        b_valid, b_done, b_busy, b_lockup;
   logic [3:0]  b_state;

   logic        c_load;
   logic [15:0] c_seed;
   logic [16:0] c_taps;
   logic        c_mode;
   logic        c_start;
   logic [15:0] c_length;
   logic        c_ready;
   logic [0:0]  c_data;
   logic        c_valid, c_done, c_busy, c_lockup;
   logic [15:0] c_state;

   int n_checks = 0;
   int n_errors = 0;

   // Hand-derived Fibonacci sequence for taps[4:1] = 4'b1100 from seed 4'b0001.
   localparam logic [3:0] FIB_ST [16] = '{
      4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
      4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001
   };

   always #5 clk = ~clk;

   lfsr_keystream #(.DATA_WIDTH(4), .OUT_WIDTH(1), .LEN_WIDTH(16)) u_dut_a (
      .clk (clk), .rst (rst), .i_load (ab_load), .i_seed (ab_seed), .i_taps (ab_taps),
      .i_mode (ab_mode), .i_start (ab_start), .i_length (ab_length), .o_out_data (a_data),
      .o_out_valid (a_valid), .i_out_ready (ab_ready), .o_done (a_done), .o_busy (a_busy),
      .o_lockup (a_lockup), .o_state (a_state)
   );

   lfsr_keystream #(.DATA_WIDTH(4), .OUT_WIDTH(4), .LEN_WIDTH(16)) u_dut_b (
      .clk (clk), .rst (rst), .i_load (ab_load), .i_seed (ab_seed), .i_taps (ab_taps),
      .i_mode (ab_mode), .i_start (ab_start), .i_length (ab_length), .o_out_data (b_data),
      .o_out_valid (b_valid), .i_out_ready (ab_ready), .o_done (b_done), .o_busy (b_busy),
      .o_lockup (b_lockup), .o_state (b_state)
   );

   lfsr_keystream #(.DATA_WIDTH(16), .OUT_WIDTH(1), .LEN_WIDTH(16)) u_dut_c (
      .clk (clk), .rst (rst), .i_load (c_load), .i_seed (c_seed), .i_taps (c_taps),
      .i_mode (c_mode), .i_start (c_start), .i_length (c_length), .o_out_data (c_data),
      .o_out_valid (c_valid), .i_out_ready (c_ready), .o_done (c_done), .o_busy (c_busy),
      .o_lockup (c_lockup), .o_state (c_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [3:0] seed);
      ab_load = 1'b1;
      ab_seed = seed;
      tick();
      ab_load = 1'b0;
   endtask

   function automatic logic [15:0] gal_step(input logic [15:0] s);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      ab_load = 0; ab_seed = 0; ab_taps = 0; ab_mode = 0; ab_start = 0; ab_length = 0;
      ab_ready = 0;
      c_load = 0; c_seed = 0; c_taps = 0; c_mode = 0; c_start = 0; c_length = 0; c_ready = 0;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if ({a_valid, a_done, a_busy, a_lockup, a_data, a_state} !== 9'b0000_0_0001) begin
         n_errors++;
         $display("FAIL reset_a: got v%b d%b b%b l%b data=%b st=%b, expected all 0, st=0001",
                  a_valid, a_done, a_busy, a_lockup, a_data, a_state);
      end
      n_checks++;
      if ({b_valid, b_data, c_valid, c_state} !== {1'b0, 4'b0000, 1'b0, 16'h0001}) begin
         n_errors++;
         $display("FAIL reset_bc: got b_v=%b b_data=%b c_v=%b c_st=%h, expected 0,0000,0,0001",
                  b_valid, b_data, c_valid, c_state);
      end
   endtask

   task automatic test_fib_ow1();
      load_a(4'b0001);
      n_checks++;
      if ({a_state, a_lockup} !== 5'b0001_0) begin
         n_errors++;
         $display("FAIL fib_load: got st=%b lock=%b, expected 0001 0", a_state, a_lockup);
      end
      ab_taps = 5'b11000; ab_mode = 1'b0; ab_ready = 1'b1;
      ab_start = 1'b1; ab_length = 16'd15;
      tick();
      ab_start = 1'b0;
      for (int k = 0; k < 15; k++) begin
         n_checks++;
         if ({a_valid, a_data, a_state} !== {1'b1, FIB_ST[k][3], FIB_ST[k+1]}) begin
            n_errors++;
            $display("FAIL fib_word%0d: got v=%b bit=%b st=%b, expected 1 %b %b",
                     k, a_valid, a_data, a_state, FIB_ST[k][3], FIB_ST[k+1]);
         end
         tick();
      end
      n_checks++;
      if ({a_done, a_valid, a_busy, a_state} !== 7'b100_0001) begin
         n_errors++;
         $display("FAIL fib_done: got done=%b v=%b busy=%b st=%b, expected 1 0 0 0001",
                  a_done, a_valid, a_busy, a_state);
      end
      tick();
      n_checks++;
      if (a_done !== 1'b0) begin
         n_errors++;
         $display("FAIL fib_done_pulse: got done=%b, expected 0", a_done);
      end
   endtask

   task automatic test_word4();
      load_a(4'b0001);
      ab_start = 1'b1; ab_length = 16'd2;
      tick();
      ab_start = 1'b0;
      n_checks++;
      if ({b_valid, b_data, b_state} !== 9'b1_0001_0011) begin
         n_errors++;
         $display("FAIL w4_first: got v=%b data=%b st=%b, expected 1 0001 0011",
                  b_valid, b_data, b_state);
      end
      tick();
      n_checks++;
      if ({b_valid, b_data} !== 5'b1_0011) begin
         n_errors++;
         $display("FAIL w4_second: got v=%b data=%b, expected 1 0011", b_valid, b_data);
      end
      tick();
      n_checks++;
      if ({b_done, b_valid, b_busy, b_state} !== 7'b100_0101) begin
         n_errors++;
         $display("FAIL w4_end: got done=%b v=%b busy=%b st=%b, expected 1 0 0 0101",
                  b_done, b_valid, b_busy, b_state);
      end
   endtask

   task automatic test_back_pressure();
      load_a(4'b0001);
      ab_start = 1'b1; ab_length = 16'd6;
      tick();
      ab_start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if ({a_valid, a_data, a_state} !== {1'b1, FIB_ST[k][3], FIB_ST[k+1]}) begin
            n_errors++;
            $display("FAIL bp_word%0d: got v=%b bit=%b st=%b, expected 1 %b %b",
                     k, a_valid, a_data, a_state, FIB_ST[k][3], FIB_ST[k+1]);
         end
         if (k == 3) begin
            ab_ready = 1'b0;
            ab_taps = 5'b10101; ab_mode = 1'b1;
            for (int s = 0; s < 3; s++) begin
               tick();
               n_checks++;
               if ({a_valid, a_data, a_state} !== {1'b1, FIB_ST[3][3], FIB_ST[4]}) begin
                  n_errors++;
                  $display("FAIL bp_stall%0d: got v=%b bit=%b st=%b, expected 1 %b %b",
                           s, a_valid, a_data, a_state, FIB_ST[3][3], FIB_ST[4]);
               end
            end
            ab_ready = 1'b1;
         end
         tick();
      end
      ab_taps = 5'b11000; ab_mode = 1'b0;
      n_checks++;
      if ({a_done, a_valid, a_state} !== {2'b10, FIB_ST[6]}) begin
         n_errors++;
         $display("FAIL bp_done: got done=%b v=%b st=%b, expected 1 0 %b",
                  a_done, a_valid, a_state, FIB_ST[6]);
      end
   endtask

   task automatic test_length_zero();
      ab_start = 1'b1; ab_length = 16'd0;
      tick();
      ab_start = 1'b0;
      n_checks++;
      if ({a_valid, a_busy, a_done, a_state} !== 7'b001_1101) begin
         n_errors++;
         $display("FAIL len0: got v=%b busy=%b done=%b st=%b, expected 0 0 1 1101",
                  a_valid, a_busy, a_done, a_state);
      end
      tick();
      n_checks++;
      if ({a_valid, a_done} !== 2'b00) begin
         n_errors++;
         $display("FAIL len0_after: got v=%b done=%b, expected 0 0", a_valid, a_done);
      end
   endtask

   task automatic test_load_zero();
      load_a(4'b0000);
      n_checks++;
      if ({a_state, a_lockup} !== 5'b0001_1) begin
         n_errors++;
         $display("FAIL seed0: got st=%b lock=%b, expected 0001 1", a_state, a_lockup);
      end
      load_a(4'b0011);
      n_checks++;
      if ({a_state, a_lockup} !== 5'b0011_0) begin
         n_errors++;
         $display("FAIL seed_clear: got st=%b lock=%b, expected 0011 0", a_state, a_lockup);
      end
      ab_load = 1'b1; ab_seed = 4'b0100; ab_start = 1'b1; ab_length = 16'd5;
      tick();
      ab_load = 1'b0; ab_start = 1'b0;
      n_checks++;
      if ({a_valid, a_busy, a_state} !== 6'b00_0100) begin
         n_errors++;
         $display("FAIL load_wins: got v=%b busy=%b st=%b, expected 0 0 0100",
                  a_valid, a_busy, a_state);
      end
   endtask

   task automatic test_run_load_rst();
      load_a(4'b0001);
      ab_start = 1'b1; ab_length = 16'd10;
      tick();
      ab_start = 1'b0;
      tick();
      ab_load = 1'b1; ab_seed = 4'b1111;
      tick();
      ab_load = 1'b0;
      n_checks++;
      if ({a_valid, a_data, a_state} !== {1'b1, FIB_ST[2][3], FIB_ST[3]}) begin
         n_errors++;
         $display("FAIL run_load: got v=%b bit=%b st=%b, expected 1 %b %b",
                  a_valid, a_data, a_state, FIB_ST[2][3], FIB_ST[3]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({a_valid, a_busy, a_done, a_lockup, a_data, a_state} !== 9'b0000_0_0001) begin
         n_errors++;
         $display("FAIL run_rst: got v=%b busy=%b done=%b lock=%b data=%b st=%b, expected 0s 0001",
                  a_valid, a_busy, a_done, a_lockup, a_data, a_state);
      end
   endtask

   task automatic test_back_to_back();
      ab_taps = 5'b11000; ab_mode = 1'b0; ab_ready = 1'b1;
      ab_start = 1'b1; ab_length = 16'd1;
      tick();
      tick();
      n_checks++;
      if ({a_done, a_valid, a_busy} !== 3'b100) begin
         n_errors++;
         $display("FAIL b2b_done: got done=%b v=%b busy=%b, expected 1 0 0",
                  a_done, a_valid, a_busy);
      end
      tick();
      ab_start = 1'b0;
      n_checks++;
      if ({a_valid, a_busy, a_done, a_data, a_state} !== {4'b1100, FIB_ST[2]}) begin
         n_errors++;
         $display("FAIL b2b_restart: got v=%b busy=%b done=%b bit=%b st=%b, expected 1 1 0 0 %b",
                  a_valid, a_busy, a_done, a_data, a_state, FIB_ST[2]);
      end
      tick();
      n_checks++;
      if (a_done !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_done2: got done=%b, expected 1", a_done);
      end
   endtask

   task automatic test_lockup_degenerate();
      logic [3:0] exp_st [4];
      logic       exp_bit [4];
      exp_st = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_bit = '{1'b0, 1'b0, 1'b0, 1'b1};
      load_a(4'b0001);
      ab_taps = 5'b00000;
      ab_start = 1'b1; ab_length = 16'd4;
      tick();
      ab_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({a_valid, a_data, a_state, a_lockup} !== {1'b1, exp_bit[k], exp_st[k], k == 3}) begin
            n_errors++;
            $display("FAIL lock_word%0d: got v=%b bit=%b st=%b lock=%b, expected 1 %b %b %b",
                     k, a_valid, a_data, a_state, a_lockup, exp_bit[k], exp_st[k], k == 3);
         end
         tick();
      end
      ab_taps = 5'b11000;
   endtask

   task automatic test_galois_period();
      logic [15:0] ref_st;
      logic [15:0] prev;
      int          mism;
      int          first_ret;
      c_load = 1'b1; c_seed = 16'h0001;
      tick();
      c_load = 1'b0;
      c_taps = 17'h0002D; c_mode = 1'b1; c_ready = 1'b1;
      c_start = 1'b1; c_length = 16'hFFFF;
      tick();
      c_start = 1'b0;
      ref_st = 16'h0001;
      mism = 0;
      first_ret = -1;
      for (int k = 0; k < 65535; k++) begin
         prev = ref_st;
         ref_st = gal_step(ref_st);
         if (c_state !== ref_st || c_data[0] !== prev[15] || c_valid !== 1'b1) mism++;
         if (c_state == 16'h0001 && first_ret < 0) first_ret = k;
         if (k == 15) begin
            n_checks++;
            if (c_state !== 16'h002D) begin
               n_errors++;
               $display("FAIL gal_step16: got %h expected 002d", c_state);
            end
         end
         if (k == 100) begin
            c_mode = 1'b0;
            c_taps = '0;
         end
         tick();
      end
      n_checks++;
      if (mism !== 0) begin
         n_errors++;
         $display("FAIL gal_track: got %0d model disagreements, expected 0", mism);
      end
      n_checks++;
      if (first_ret !== 65534) begin
         n_errors++;
         $display("FAIL gal_period: seed reappeared after %0d steps, expected 65535",
                  first_ret + 1);
      end
      n_checks++;
      if ({c_done, c_valid, c_state} !== {2'b10, 16'h0001}) begin
         n_errors++;
         $display("FAIL gal_done: got done=%b v=%b st=%h, expected 1 0 0001",
                  c_done, c_valid, c_state);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected run to complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_fib_ow1();
      test_word4();
      test_back_pressure();
      test_length_zero();
      test_load_zero();
      test_run_load_rst();
      test_back_to_back();
      test_lockup_degenerate();
      test_galois_period();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lfsr_keystream.md
# lfsr_keystream

Parametrised LFSR keystream generator producing OUT_WIDTH-bit words per cycle over a valid/ready stream. Supports runtime-selectable Fibonacci or Galois feedback, seed loading, run-length-controlled bursts and zero-state lockup recovery. It is the multi-bit, mode-selectable successor to the single-bit shift-enable LFSR. It feeds stream-cipher and scrambler datapaths in the crypto examples.

## Interface
- DATA_WIDTH, 16: LFSR state width, ≥2.
- OUT_WIDTH, 8: keystream bits per output word, 1..DATA_WIDTH.
- LEN_WIDTH, 16: width of the burst length counter.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  load seed, honoured only in IDLE.
- seed  in  DATA_WIDTH  initial state.
- taps  in  DATA_WIDTH+1  feedback coefficients; Fibonacci uses taps[DATA_WIDTH:1], Galois uses taps[DATA_WIDTH-1:0].
- mode  in  1  0 = Fibonacci, 1 = Galois.
- start  in  1  begin a burst, honoured only in IDLE and when load is low.
- length  in  LEN_WIDTH  words in the burst.
- out_data  out  OUT_WIDTH  keystream word; first-generated bit in the MSB.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- done  out  1  one-cycle pulse at burst end.
- busy  out  1  high in RUN.
- lockup  out  1  sticky; zero state detected and reseeded.
- state  out  DATA_WIDTH  current state_reg.

## Operation
- Single step from state s, with msb = s[DATA_WIDTH-1] as the output bit:
  - Fibonacci: s' = {s[DATA_WIDTH-2:0], ^(s & taps[DATA_WIDTH:1])}.
  - Galois: s' = {s[DATA_WIDTH-2:0], 1'b0} ^ ({DATA_WIDTH{msb}} & taps[DATA_WIDTH-1:0]).
- Word generation: OUT_WIDTH steps unrolled combinationally in one cycle. The bit from the first step goes to out_data[OUT_WIDTH-1].
- taps and mode are registered at start and held for the whole burst. Changes mid-burst have no effect.
- FSM IDLE:
  - load: state_reg <= seed. If seed == 0, state_reg <= 1 instead and lockup <= 1. Otherwise lockup <= 0.
  - start with length == 0: done pulses next cycle, FSM stays IDLE, state unchanged.
  - start with length > 0: out_data <= word(state_reg), state_reg <= state after OUT_WIDTH steps, out_valid <= 1, remaining <= length, go to RUN.
  - load and start in the same cycle: load wins, start is ignored.
- FSM RUN:
  - An accept (out_valid & out_ready) with remaining > 1: present the next word, advance state, decrement remaining. out_valid stays high.
  - An accept with remaining == 1: out_valid <= 0, done <= 1 for one cycle, go to IDLE.
  - No accept: out_data, state_reg and remaining hold. out_valid must not drop.
  - load and start are ignored.
- Lockup: if any advanced state equals 0 (degenerate taps), state_reg <= 1 and lockup <= 1. The already-computed word is still delivered.
- Advanced state: register tracks 0..2^LEN_WIDTH-1 words; no wrap because remaining only counts down.

## Timing
- Reset values: state_reg = 1, FSM IDLE, out_data = 0, out_valid = 0, done = 0, busy = 0, lockup = 0, remaining = 0, stored taps/mode = 0.
- start sampled at cycle t gives out_valid high at t+1.
- With out_ready held high, throughput is one word per cycle and the last accept is at t+length.
- done is high in the cycle after the last accept, together with out_valid = 0 and busy = 0.
- The next start is accepted in the same cycle done is high.
- rst mid-burst: all registers return to reset values next cycle and the burst is abandoned.

## Structure
- lfsr_pkg holds:
  - typedef enum {LFSR_FIBONACCI, LFSR_GALOIS} lfsr_mode_e.
  - FSM enum {ST_IDLE, ST_RUN}.
  - constant LFSR_RESEED = 1.
- Sub-module lfsr_step_n: combinational; inputs state, taps, mode; outputs an OUT_WIDTH word and the next state. Internally a generate loop of single steps.
- Top module: FSM, output register, remaining counter, lockup logic.

## Test plan
- DATA_WIDTH=4, OUT_WIDTH=1, Fibonacci, taps[4:1]=4'b1100, seed 4'b0001, length 15:
  - states run 0001,0010,0100,1001,0011,…,1000.
  - output starts 0,0,0,1.
  - state returns to 0001 after 15 words.
  - done at t+16.
- Same taps, OUT_WIDTH=4, length 2: words 4'b0001 then 4'b0011; final state 4'b0101.
- Back-pressure: out_ready low for 3 cycles mid-burst gives out_data and out_valid stable, no word lost or duplicated versus the golden model.
- length=0 start: no out_valid; done pulses one cycle; state unchanged. load with seed=0: state=1, lockup=1.
- rst asserted in RUN: next cycle out_valid=0, busy=0, state=1. load asserted in RUN is ignored.
- Galois mode, DATA_WIDTH=16, taps[15:0]=16'h002D: period equals 65535 steps, compared against a reference model.
